// File: rtl/host_link_pkg.sv
// Shared types and constants for the host command link: RX/TX state
// encodings, frame geometry and the default inter-byte timeout.
package host_link_pkg;

    localparam int CMD_BYTES          = 3;
    localparam int BYTE_W             = 8;
    localparam int CMD_W              = CMD_BYTES * BYTE_W;
    localparam int TIMEOUT_CYCLES_DEF = 100000;

    typedef enum logic [1:0] {
        RX_B0   = 2'd0,
        RX_B1   = 2'd1,
        RX_B2   = 2'd2,
        RX_HOLD = 2'd3
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

endpackage

// File: rtl/host_link_tx.sv
// Response transmit path: hands response bytes to the UART transmitter,
// with a single pending slot so one byte can queue behind the one in flight.
module host_link_tx
    import host_link_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] resp_data,
    input  logic              send_resp,
    input  logic              tx_done,
    output logic [BYTE_W-1:0] tx_data,
    output logic              trmt,
    output logic              resp_sent,
    output logic              tx_overrun
);

    tx_state_t         state_reg, state_next;
    logic [BYTE_W-1:0] tx_data_reg, tx_data_next;
    logic              trmt_reg, trmt_next;
    logic              resp_sent_reg, resp_sent_next;
    logic              overrun_reg, overrun_next;
    logic              pend_valid_reg, pend_valid_next;
    logic [BYTE_W-1:0] pend_data_reg, pend_data_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= TX_IDLE;
            tx_data_reg    <= '0;
            trmt_reg       <= 1'b0;
            resp_sent_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_data_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            tx_data_reg    <= tx_data_next;
            trmt_reg       <= trmt_next;
            resp_sent_reg  <= resp_sent_next;
            overrun_reg    <= overrun_next;
            pend_valid_reg <= pend_valid_next;
            pend_data_reg  <= pend_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        tx_data_next    = tx_data_reg;
        trmt_next       = 1'b0;
        resp_sent_next  = 1'b0;
        overrun_next    = 1'b0;
        pend_valid_next = pend_valid_reg;
        pend_data_next  = pend_data_reg;
        case (state_reg)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_next = resp_data;
                    trmt_next    = 1'b1;
                    state_next   = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_next = 1'b1;
                    if (pend_valid_reg) begin
                        // Drain the slot; a coincident request refills it.
                        tx_data_next    = pend_data_reg;
                        trmt_next       = 1'b1;
                        pend_valid_next = send_resp;
                        if (send_resp) begin
                            pend_data_next = resp_data;
                        end
                    end else if (send_resp) begin
                        // Empty slot drained in the same cycle: go straight out.
                        tx_data_next = resp_data;
                        trmt_next    = 1'b1;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end else if (send_resp) begin
                    if (!pend_valid_reg) begin
                        pend_valid_next = 1'b1;
                        pend_data_next  = resp_data;
                    end else begin
                        overrun_next = 1'b1;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    assign tx_data    = tx_data_reg;
    assign trmt       = trmt_reg;
    assign resp_sent  = resp_sent_reg;
    assign tx_overrun = overrun_reg;

endmodule

// File: rtl/host_cmd_link.sv
// Host command link: assembles 3-byte MSB-first command frames from the UART
// receiver with an inter-byte timeout, and forwards core responses to the UART.
module host_cmd_link
    import host_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              clr_rx_rdy,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    input  logic [BYTE_W-1:0] resp_data,
    input  logic              send_resp,
    output logic              resp_sent,
    output logic [BYTE_W-1:0] tx_data,
    output logic              trmt,
    input  logic              tx_done,
    output logic              frame_err,
    output logic              tx_overrun
);

    localparam int ASM_W = (CMD_BYTES - 1) * BYTE_W;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    rx_state_t         rx_state_reg, rx_state_next;
    logic [ASM_W-1:0]  asm_reg, asm_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CMD_W-1:0]  cmd_reg, cmd_next;
    logic              cmd_rdy_reg, cmd_rdy_next;
    logic              frame_err_reg, frame_err_next;
    logic              capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg  <= RX_B0;
            asm_reg       <= '0;
            cnt_reg       <= '0;
            cmd_reg       <= '0;
            cmd_rdy_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_state_reg  <= rx_state_next;
            asm_reg       <= asm_next;
            cnt_reg       <= cnt_next;
            cmd_reg       <= cmd_next;
            cmd_rdy_reg   <= cmd_rdy_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        rx_state_next  = rx_state_reg;
        asm_next       = asm_reg;
        cnt_next       = cnt_reg;
        cmd_next       = cmd_reg;
        cmd_rdy_next   = cmd_rdy_reg;
        frame_err_next = 1'b0;
        capture        = 1'b0;
        case (rx_state_reg)
            RX_B0: begin
                cnt_next = '0;
                if (rx_rdy) begin
                    capture                      = 1'b1;
                    asm_next[ASM_W-1 -: BYTE_W]  = rx_data;
                    rx_state_next                = RX_B1;
                end
            end
            RX_B1, RX_B2: begin
                if (cnt_reg == CNT_LAST) begin
                    // Timeout wins; a byte arriving now opens a fresh frame.
                    frame_err_next = 1'b1;
                    cnt_next       = '0;
                    asm_next       = '0;
                    rx_state_next  = RX_B0;
                    if (rx_rdy) begin
                        capture                     = 1'b1;
                        asm_next[ASM_W-1 -: BYTE_W] = rx_data;
                        rx_state_next               = RX_B1;
                    end
                end else if (rx_rdy) begin
                    capture  = 1'b1;
                    cnt_next = '0;
                    if (rx_state_reg == RX_B1) begin
                        asm_next[BYTE_W-1:0] = rx_data;
                        rx_state_next        = RX_B2;
                    end else begin
                        cmd_next      = {asm_reg, rx_data};
                        cmd_rdy_next  = 1'b1;
                        rx_state_next = RX_HOLD;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RX_HOLD: begin
                // Incoming bytes stay parked in the UART until the core acks.
                cnt_next = '0;
                if (clr_cmd_rdy) begin
                    cmd_rdy_next  = 1'b0;
                    rx_state_next = RX_B0;
                end
            end
            default: rx_state_next = RX_B0;
        endcase
    end

    assign clr_rx_rdy = capture & ~rst;
    assign cmd        = cmd_reg;
    assign cmd_rdy    = cmd_rdy_reg;
    assign frame_err  = frame_err_reg;

    host_link_tx u_tx (
        .clk        (clk),
        .rst        (rst),
        .resp_data  (resp_data),
        .send_resp  (send_resp),
        .tx_done    (tx_done),
        .tx_data    (tx_data),
        .trmt       (trmt),
        .resp_sent  (resp_sent),
        .tx_overrun (tx_overrun)
    );

endmodule

// File: tb/tb_host_cmd_link.sv
// Randomized scoreboard bench for host_cmd_link: a byte/frame level reference
// model predicts commands, frame errors and response traffic, a monitor checks.
module tb_host_cmd_link;

    localparam int TMO = 64;  // long enough for 50-cycle byte spacing to fit a frame

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp_data = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done = 1'b0;
    logic        frame_err;
    logic        tx_overrun;

    host_cmd_link #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
        .resp_sent(resp_sent), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .frame_err(frame_err), .tx_overrun(tx_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct { logic [23:0] val; int at; } exp_cmd_t;
    typedef struct { logic [7:0] val; int at; } exp_tx_t;
    exp_cmd_t    exp_cmd_q[$];
    exp_tx_t     exp_tx_q[$];
    int          exp_rs_q[$];
    int          exp_ov_q[$];
    int          exp_fe_q[$];
    int          got_fe_q[$];

    // RX reference: bytes of the frame in progress plus when the last one landed
    logic [7:0]  partial[$];
    int          last_c = 0;
    logic [23:0] last_cmd = 24'h0;

    // TX reference: one byte on the wire, at most one waiting
    bit          in_flight = 0;
    logic [7:0]  pend_q[$];

    int clr_cnt = 0, ov_cnt = 0, rs_cnt = 0, trmt_cnt = 0;
    bit auto_ack = 0;
    logic cmd_rdy_d = 1'b0;

    task automatic model_rx(input logic [7:0] b, input int c);
        logic [23:0] v;
        if (partial.size() > 0 && c - last_c >= TMO) begin
            exp_fe_q.push_back(last_c + TMO + 1);
            partial.delete();
        end
        partial.push_back(b);
        last_c = c;
        if (partial.size() == 3) begin
            v = {partial[0], partial[1], partial[2]};
            exp_cmd_q.push_back('{val: v, at: c + 1});
            last_cmd = v;
            partial.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_flight = 0;
            pend_q.delete();
            exp_tx_q.delete();
            exp_rs_q.delete();
            exp_ov_q.delete();
        end else begin
            if (tx_done && in_flight) begin
                exp_rs_q.push_back(cyc + 1);
                if (pend_q.size() > 0) exp_tx_q.push_back('{val: pend_q.pop_front(), at: cyc + 1});
                else in_flight = 0;
            end
            if (send_resp) begin
                if (!in_flight) begin
                    exp_tx_q.push_back('{val: resp_data, at: cyc + 1});
                    in_flight = 1;
                end else if (pend_q.size() == 0) begin
                    pend_q.push_back(resp_data);
                end else begin
                    exp_ov_q.push_back(cyc + 1);
                end
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_cmd_t ec;
        exp_tx_t  et;
        if (!rst) begin
            if (cmd_rdy && !cmd_rdy_d) begin
                if (exp_cmd_q.size() == 0) chk("cmd_unexpected", exp_cmd_q.size(), 1);
                else begin
                    ec = exp_cmd_q.pop_front();
                    chk("cmd_value", cmd, ec.val);
                    chk("cmd_rdy_cycle", cyc, ec.at);
                    $display("cmd    cycle %0d value %06h", cyc, cmd);
                end
            end
            if (trmt) begin
                trmt_cnt++;
                if (exp_tx_q.size() == 0) chk("trmt_unexpected", exp_tx_q.size(), 1);
                else begin
                    et = exp_tx_q.pop_front();
                    chk("tx_data", tx_data, et.val);
                    chk("trmt_cycle", cyc, et.at);
                    $display("trmt   cycle %0d byte %02h", cyc, tx_data);
                end
            end
            if (resp_sent) begin
                rs_cnt++;
                if (exp_rs_q.size() == 0) chk("resp_sent_unexpected", exp_rs_q.size(), 1);
                else chk("resp_sent_cycle", cyc, exp_rs_q.pop_front());
            end
            if (tx_overrun) begin
                ov_cnt++;
                if (exp_ov_q.size() == 0) chk("overrun_unexpected", exp_ov_q.size(), 1);
                else chk("overrun_cycle", cyc, exp_ov_q.pop_front());
            end
            if (frame_err) got_fe_q.push_back(cyc);
            if (clr_rx_rdy) begin
                clr_cnt++;
                chk("clr_outside_hold", cmd_rdy, 1'b0);
            end
        end
        cmd_rdy_d = cmd_rdy;
    end

    // Fake UART transmitter
    initial forever begin
        @(negedge clk);
        if (trmt && !rst) begin
            repeat ($urandom_range(2, 12)) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
        end
    end

    // Core acknowledging commands
    initial forever begin
        @(negedge clk);
        if (auto_ack && cmd_rdy && !rst) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk);
            #1 clr_cmd_rdy = 1'b1;
            @(posedge clk);
            #1 clr_cmd_rdy = 1'b0;
            @(negedge clk);
            chk("cmd_rdy_fall", cmd_rdy, 1'b0);
        end
    end

    task automatic rx_consume(input logic [7:0] b);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!clr_rx_rdy && n < 500);
        chk("rx_byte_consumed", clr_rx_rdy, 1'b1);
        if (clr_rx_rdy) model_rx(b, cyc);
        @(posedge clk);
        #1 rx_rdy = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1 rx_data = b;
        rx_rdy = 1'b1;
        rx_consume(b);
    endtask

    task automatic rx_flush();
        if (partial.size() > 0) begin
            exp_fe_q.push_back(last_c + TMO + 1);
            partial.delete();
        end
        repeat (TMO + 4) @(posedge clk);
        #1;
    endtask

    task automatic tx_send(input logic [7:0] b);
        resp_data = b;
        send_resp = 1'b1;
        @(posedge clk);
        #1 send_resp = 1'b0;
    endtask

    task automatic rx_random();
        int r, g;
        repeat (45) begin
            r = $urandom_range(0, 9);
            case (r)
                5:       g = TMO - 2;
                6:       g = TMO - 1;
                7:       g = TMO + 4;
                8, 9:    g = $urandom_range(0, 3);
                default: g = $urandom_range(0, 10);
            endcase
            rx_byte(8'($urandom_range(0, 255)), g);
        end
    endtask

    task automatic tx_random();
        repeat (60) begin
            repeat ($urandom_range(1, 8)) @(posedge clk);
            #1 tx_send(8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        int base_clr, base_ov, base_rs, base_trmt, base_fe;
        int n;

        #500000;
        $display("FAIL watchdog: running at cycle %0d, expected finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_clr, base_ov, base_rs, base_trmt, base_fe;
        int nfe;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {cmd, tx_data, cmd_rdy, trmt, resp_sent, frame_err, tx_overrun, clr_rx_rdy}, 64'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Three spaced bytes form one command
        base_clr = clr_cnt;
        rx_byte(8'h02, 49);
        rx_byte(8'h1F, 49);
        rx_byte(8'hA5, 49);
        chk("frame_clr_pulses", clr_cnt - base_clr, 3);
        chk("cmd_rdy_held", cmd_rdy, 1'b1);

        // Backpressure while the command is unacknowledged
        base_clr = clr_cnt;
        rx_data = 8'h33;
        rx_rdy  = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("hold_no_consume", clr_cnt - base_clr, 0);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        chk("ack_cycle_no_consume", clr_rx_rdy, 1'b0);
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
        chk("cmd_rdy_after_ack", cmd_rdy, 1'b0);
        chk("cmd_retained", cmd, 24'h021FA5);
        auto_ack = 1;
        rx_consume(8'h33);
        rx_byte(8'h44, 2);
        rx_byte(8'h55, 2);

        // Partial frame times out
        base_fe = got_fe_q.size();
        rx_byte(8'h11, 3);
        rx_byte(8'h22, 3);
        rx_flush();
        chk("timeout_frame_err", got_fe_q.size() - base_fe, 1);
        chk("cmd_unchanged_after_timeout", cmd, last_cmd);
        rx_byte(8'h01, 3);
        rx_byte(8'h02, 3);
        rx_byte(8'h03, 3);
        repeat (8) @(posedge clk);
        #1;
        chk("cmd_after_recovery", cmd, 24'h010203);

        // Response queueing and overrun
        base_ov = ov_cnt; base_rs = rs_cnt; base_trmt = trmt_cnt;
        tx_send(8'hA5);
        tx_send(8'h5A);
        tx_send(8'hFF);
        repeat (60) @(posedge clk);
        #1;
        chk("overrun_count", ov_cnt - base_ov, 1);
        chk("resp_sent_count", rs_cnt - base_rs, 2);
        chk("trmt_count", trmt_cnt - base_trmt, 2);

        // Reset mid-frame and mid-transmit
        base_fe = got_fe_q.size(); base_rs = rs_cnt; base_ov = ov_cnt;
        rx_byte(8'h77, 3);
        tx_send(8'h9C);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        partial.delete();
        last_cmd = 24'h0;
        chk("midrun_reset_outputs", {cmd, tx_data, cmd_rdy, trmt, resp_sent, frame_err, tx_overrun, clr_rx_rdy}, 64'h0);
        repeat (20) @(posedge clk);
        #1;
        rx_byte(8'hAA, 3);
        rx_byte(8'hBB, 3);
        rx_byte(8'hCC, 3);
        repeat (8) @(posedge clk);
        #1;
        chk("cmd_after_reset", cmd, 24'hAABBCC);
        chk("no_frame_err_after_reset", got_fe_q.size() - base_fe, 0);
        chk("no_resp_sent_after_reset", rs_cnt - base_rs, 0);
        chk("no_overrun_after_reset", ov_cnt - base_ov, 0);

        // Concurrent randomized traffic on both paths
        fork
            rx_random();
            tx_random();
        join
        rx_flush();
        repeat (60) @(posedge clk);
        #1;

        chk("cmd_leftover", exp_cmd_q.size(), 0);
        chk("tx_leftover", exp_tx_q.size(), 0);
        chk("resp_sent_leftover", exp_rs_q.size(), 0);
        chk("overrun_leftover", exp_ov_q.size(), 0);
        chk("frame_err_total", got_fe_q.size(), exp_fe_q.size());
        nfe = (got_fe_q.size() < exp_fe_q.size()) ? got_fe_q.size() : exp_fe_q.size();
        for (int i = 0; i < nfe; i++) chk("frame_err_cycle", got_fe_q[i], exp_fe_q[i]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
